// File: rtl/ram_rd_pkg.sv
// Shared types and helpers for the RAM burst read path.
// Holds the controller state set, buffer sizing and read-latency lookup.
package ram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    localparam int RD_BUF_DEPTH = 4;
    localparam int CNT_WIDTH    = $clog2(RD_BUF_DEPTH + 1);
    localparam int PTR_WIDTH    = $clog2(RD_BUF_DEPTH);

    function automatic int rd_lat(input logic [31:0] mode);
        return (mode == "fwft") ? 0 : 1;
    endfunction

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// Small return-data buffer between the RAM read port and the output stage.
// The head entry is visible combinationally; pop advances it.
module ram_rd_skid_fifo
    import ram_rd_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head,
    output logic [CNT_WIDTH-1:0] count
);

    logic [WIDTH-1:0]     mem_q [RD_BUF_DEPTH];
    logic [WIDTH-1:0]     mem_d [RD_BUF_DEPTH];
    logic [PTR_WIDTH-1:0] wr_q, wr_d;
    logic [PTR_WIDTH-1:0] rd_q, rd_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 do_push;
    logic                 do_pop;

    always_comb begin
        do_push = push && (cnt_q != CNT_WIDTH'(RD_BUF_DEPTH));
        do_pop  = pop && (cnt_q != '0);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        // Push and pop together leave the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read controller for RAM port B: issues wrapped sequential reads
// under a small credit window and streams the words out with a last flag.
module ram_burst_reader
    import ram_rd_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter int          DATA_DEPTH = 64,
    parameter int          ADDR_WIDTH = 6,
    parameter int          LEN_WIDTH  = 8,
    parameter logic [31:0] RD_MODE    = "std"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
);

    localparam int RD_LAT = rd_lat(RD_MODE);
    localparam int RW     = LEN_WIDTH + 1;

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [RW-1:0]         rem_q, rem_d;
    logic                  pend_q, pend_d;
    logic                  pend_last_q, pend_last_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;

    logic [CNT_WIDTH-1:0]  fifo_count;
    logic [DATA_WIDTH:0]   fifo_head;
    logic [DATA_WIDTH:0]   fifo_in;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  outstanding;
    logic [CNT_WIDTH:0]    used;
    logic                  credit_ok;
    logic                  issue;
    logic                  issue_last;
    logic                  last_acc;

    // Reads in flight plus buffered words may never exceed the buffer.
    always_comb begin
        outstanding = (RD_LAT != 0) && pend_q;
        used        = {1'b0, fifo_count} + {{CNT_WIDTH{1'b0}}, outstanding};
        credit_ok   = used < (CNT_WIDTH + 1)'(RD_BUF_DEPTH);
        issue       = (state_q == ISSUE) && credit_ok;
        issue_last  = (rem_q == RW'(1));
        pend_d      = issue;
        pend_last_d = issue && issue_last;
        if (RD_LAT == 0) begin
            fifo_push = issue;
            fifo_in   = {issue_last, ram_dout};
        end else begin
            fifo_push = pend_q;
            fifo_in   = {pend_last_q, ram_dout};
        end
        fifo_pop = (fifo_count != '0) && (!m_valid_q || m_ready);
        last_acc = m_valid_q && m_ready && m_last_q;
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        if (fifo_pop) begin
            m_valid_d = 1'b1;
            m_last_d  = fifo_head[DATA_WIDTH];
            m_data_d  = fifo_head[DATA_WIDTH-1:0];
        end else if (m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rem_d   = RW'(cmd_len) + RW'(1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d = (addr_q == ADDR_WIDTH'(DATA_DEPTH - 1))
                           ? '0 : addr_q + 1'b1;
                    rem_d  = rem_q - RW'(1);
                    if (issue_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_acc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
        end
    end

    ram_rd_skid_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(fifo_in),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign ram_en    = issue;
    assign ram_addr  = addr_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Read-side controller for the team's dual-port RAM (ram_rtl) read port B.
- Accepts a burst command (start address, beat count) over a valid/ready handshake.
- Issues sequential reads with wrap-around at the RAM depth and compensates for the RAM read latency (RD_MODE "std" or "fwft").
- Presents the returned words as a backpressured stream with a last-beat flag, for use by FIFO and packet readers.

Parameters:
- DATA_WIDTH, 8, RAM word width; must equal the RAM RD_DATA_WIDTH.
- DATA_DEPTH, 64, RAM depth in words; any value >= 2, not required to be a power of two.
- ADDR_WIDTH, 6, address width; must be >= clog2(DATA_DEPTH).
- LEN_WIDTH, 8, burst length field width.
- RD_MODE, "std", must match the RAM setting. "std" = ram_dout valid 1 cycle after ram_en. "fwft" = ram_dout valid in the same cycle as ram_en/ram_addr.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  ADDR_WIDTH  first read address; must be < DATA_DEPTH.
- cmd_len  in  LEN_WIDTH  beats minus 1 (0 means 1 beat).
- ram_en  out  1  RAM read enable (drives enb).
- ram_addr  out  ADDR_WIDTH  RAM read address (drives addrb).
- ram_dout  in  DATA_WIDTH  RAM read data (from doutb).
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream sink ready.
- m_data  out  DATA_WIDTH  stream data.
- m_last  out  1  final beat of the burst.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: cmd_ready=0 while rst is high, 1 in the first cycle after release. ram_en=0, ram_addr=0, m_valid=0, m_data=0, m_last=0, busy=0. FIFO is emptied and all counters are cleared.
- RD_LAT is 1 for "std" and 0 for "fwft".
- A command is accepted on a clock edge where cmd_valid and cmd_ready are both high. The block latches addr and remaining = cmd_len+1, then moves to ISSUE.
- FSM states:
  - IDLE: waits for a command.
  - ISSUE: transitions to DRAIN when the last read is issued.
  - DRAIN: waits until the last beat is accepted (m_valid && m_ready && m_last), then returns to IDLE.
  - Reading and output are pipelined, so ISSUE and DRAIN can overlap with output beats.
- Credit rule: ram_en is asserted in a cycle only if outstanding + fifo_count < 4, where outstanding counts reads in flight (0..RD_LAT). At most 1 read is issued per cycle.
- Address sequence: ram_addr increments by 1 per issued read. After DATA_DEPTH-1 it wraps to 0. ram_addr holds its value when ram_en=0.
- Data capture: ram_dout is written into the 4-entry FIFO RD_LAT cycles after its ram_en, tagged with last = (issued read was beat number len). The FIFO head drives m_data and m_last, registered.
- Latency from the command handshake edge:
  - ram_en first asserted in the next cycle.
  - First m_valid at handshake + 2 + RD_LAT cycles.
- Throughput: with m_ready held high, 1 beat per cycle and no bubbles after the first beat.
- Backpressure: m_data and m_last stay stable while m_valid && !m_ready. No beat is lost or duplicated. ram_en drops once credit is exhausted.
- cmd_ready rises in the cycle after the last-beat handshake. cmd_valid is ignored while busy.
- A simultaneous FIFO push and pop in the same cycle keeps fifo_count unchanged.
- Reset mid-burst: asynchronous clear of all state and outputs. Buffered data is discarded and no m_last is produced.

Decomposition:
- Shared package ram_rd_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN);
  - the constant RD_BUF_DEPTH=4;
  - the function rd_lat(RD_MODE).
- One sub-module, ram_rd_skid_fifo: a 4-entry synchronous FIFO of width DATA_WIDTH+1 with count output, on the same clk and rst.

Test Plan:
- "std" mode, RAM preloaded with mem[i]=i+8'h10, cmd addr=2 len=3, m_ready=1 -> m_data 8'h12, 8'h13, 8'h14, 8'h15 on consecutive cycles. m_last only on 8'h15. First m_valid 3 cycles after the handshake. cmd_ready=1 one cycle after the last beat.
- Wrap, DATA_DEPTH=64, cmd addr=62 len=3 -> ram_addr sequence 62, 63, 0, 1. Data 8'h4E, 8'h4F, 8'h10, 8'h11.
- Backpressure, addr=0 len=15, m_ready toggling 1/0 then held low for 10 cycles -> ram_en stops once outstanding+count=4. All 16 values 8'h10..8'h1F arrive in order, no duplicates. m_data is stable while stalled.
- "fwft" mode, same command as the first scenario -> same data. First m_valid 2 cycles after the handshake. 1 beat per cycle.
- cmd_len=0 at addr=7 -> single beat 8'h17 with m_last=1. A cmd_valid pulse during the burst is not accepted (cmd_ready=0), and no second burst follows.
- rst asserted for 1 cycle after the 2nd beat of a len=7 burst -> m_valid, ram_en and busy go to 0 immediately. After release, cmd addr=5 len=1 returns 8'h15, 8'h16 only.
